// File: rtl/sd_req_pkg.sv
// Shared constants for the multi-channel SD request arbiter: MCU command codes,
// grant FSM states and bit positions inside the MCU status bytes.
package sd_req_pkg;

    localparam logic [7:0] CMD_STATUS = 8'd1;
    localparam logic [7:0] CMD_GO     = 8'd2;
    localparam logic [7:0] CMD_ABORT  = 8'd6;

    // Grant index is always carried as 3 bits so the status byte layout is fixed.
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ACTIVE  = 2'd2
    } grant_state_e;

    localparam int STAT_GRANTED_BIT = 7;
    localparam int STAT_BE_BUSY_BIT = 6;
    localparam int STAT_ACTIVE_BIT  = 5;
    localparam int STAT_DIR_BIT     = 7;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pend searching upward from
// rr_ptr+1, wrapping modulo NUM_CH.
module rr_pick
    import sd_req_pkg::*;
#(
    parameter int NUM_CH = 5
) (
    input  logic [NUM_CH-1:0] pend,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    int              cand;
    logic [CH_W-1:0] cand_i;

    // Scan from the farthest candidate down so the nearest pending channel wins.
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        cand   = 0;
        cand_i = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_i = CH_W'(cand);
            if (pend[cand_i]) begin
                idx   = IDX_W'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Multi-channel SD sector request arbiter: captures per-channel read/write requests,
// grants them round-robin, hands the grant to the MCU and drives the SD backend.
module sd_req_arbiter
    import sd_req_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int SECTOR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req_rd,
    input  logic [NUM_CH-1:0]          req_wr,
    input  logic [NUM_CH*SECTOR_W-1:0] req_sector,
    output logic [NUM_CH-1:0]          ch_done,
    output logic [NUM_CH-1:0]          ch_err,
    input  logic                       data_strobe,
    input  logic                       data_start,
    input  logic [7:0]                 data_in,
    output logic [7:0]                 data_out,
    output logic                       irq,
    input  logic                       iack,
    output logic                       be_rstart,
    output logic                       be_wstart,
    output logic [SECTOR_W-1:0]        be_sector,
    input  logic                       be_busy,
    input  logic                       be_done
);

    localparam int SB   = SECTOR_W / 8;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    grant_state_e         state_q, state_d;
    logic [IDX_W-1:0]     grant_ch_q, grant_ch_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]    pend_q, pend_d;
    logic [NUM_CH-1:0]    dir_q, dir_d;
    logic [SECTOR_W-1:0]  sec_q [NUM_CH];
    logic [SECTOR_W-1:0]  sec_d [NUM_CH];
    logic [NUM_CH-1:0]    req_rd_q, req_wr_q;
    logic                 irq_q, irq_d;
    logic [NUM_CH-1:0]    ch_done_q, ch_done_d;
    logic [NUM_CH-1:0]    ch_err_q, ch_err_d;
    logic [7:0]           data_out_q, data_out_d;
    logic [7:0]           command_q, command_d;
    logic [3:0]           byte_cnt_q, byte_cnt_d;
    logic [SECTOR_W-1:0]  tsec_q, tsec_d;
    logic [SECTOR_W-1:0]  be_sector_q, be_sector_d;
    logic                 be_rstart_q, be_rstart_d;
    logic                 be_wstart_q, be_wstart_d;

    logic [NUM_CH-1:0]    rd_rise, wr_rise;
    logic [SECTOR_W-1:0]  req_sec [NUM_CH];
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [CH_W-1:0]      gidx;

    assign rd_rise = req_rd & ~req_rd_q;
    assign wr_rise = req_wr & ~req_wr_q;
    assign gidx    = grant_ch_q[CH_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_sec
            assign req_sec[gi] = req_sector[gi*SECTOR_W +: SECTOR_W];
        end
    endgenerate

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .pend   (pend_q),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        grant_ch_d  = grant_ch_q;
        rr_ptr_d    = rr_ptr_q;
        pend_d      = pend_q;
        dir_d       = dir_q;
        sec_d       = sec_q;
        irq_d       = irq_q;
        ch_done_d   = '0;
        ch_err_d    = '0;
        data_out_d  = data_out_q;
        command_d   = command_q;
        byte_cnt_d  = byte_cnt_q;
        tsec_d      = tsec_q;
        be_sector_d = be_sector_q;
        be_rstart_d = be_rstart_q;
        be_wstart_d = be_wstart_q;

        // A channel that is still pending ignores new edges; read beats a coincident write.
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pend_q[i] && (rd_rise[i] || wr_rise[i])) begin
                pend_d[i] = 1'b1;
                dir_d[i]  = !rd_rise[i];
                sec_d[i]  = req_sec[i];
            end
        end

        if (iack) begin
            irq_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_ch_d = pick_idx;
                    state_d    = ST_GRANTED;
                    irq_d      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (be_done) begin
                    be_rstart_d     = 1'b0;
                    be_wstart_d     = 1'b0;
                    ch_done_d[gidx] = 1'b1;
                    pend_d[gidx]    = 1'b0;
                    rr_ptr_d        = grant_ch_q;
                    state_d         = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (data_strobe) begin
            if (data_start) begin
                command_d  = data_in;
                byte_cnt_d = 4'd0;
                data_out_d = '0;
                data_out_d[STAT_GRANTED_BIT] = (state_q != ST_IDLE);
                data_out_d[STAT_BE_BUSY_BIT] = be_busy;
                data_out_d[STAT_ACTIVE_BIT]  = (state_q == ST_ACTIVE);
                data_out_d[2:0]              = grant_ch_q;
            end else begin
                byte_cnt_d = (byte_cnt_q == 4'd15) ? 4'd15 : byte_cnt_q + 4'd1;
                case (command_q)
                    CMD_STATUS: begin
                        data_out_d = '0;
                        if (byte_cnt_q == 4'd0) begin
                            data_out_d[STAT_DIR_BIT] = dir_q[gidx];
                            for (int i = 0; i < NUM_CH && i < 7; i++) begin
                                data_out_d[i] = pend_q[i];
                            end
                        end else begin
                            // Byte k (1..SB) carries sector byte SB-k, i.e. MSB first.
                            for (int b = 0; b < SB; b++) begin
                                if (byte_cnt_q == 4'(SB - b)) begin
                                    data_out_d = sec_q[gidx][b*8 +: 8];
                                end
                            end
                        end
                    end
                    CMD_GO: begin
                        if (byte_cnt_q < 4'(SB)) begin
                            tsec_d     = (tsec_q << 8) | SECTOR_W'(data_in);
                            data_out_d = 8'hff;
                            if (byte_cnt_q == 4'(SB - 1) && state_q == ST_GRANTED) begin
                                be_sector_d = tsec_d;
                                be_rstart_d = !dir_q[gidx];
                                be_wstart_d = dir_q[gidx];
                                state_d     = ST_ACTIVE;
                            end
                        end else begin
                            data_out_d = {7'd0, be_rstart_q | be_wstart_q};
                        end
                    end
                    CMD_ABORT: begin
                        data_out_d = 8'h00;
                        if (byte_cnt_q == 4'd0 && state_q == ST_GRANTED) begin
                            ch_done_d[gidx] = 1'b1;
                            ch_err_d[gidx]  = 1'b1;
                            pend_d[gidx]    = 1'b0;
                            rr_ptr_d        = grant_ch_q;
                            state_d         = ST_IDLE;
                        end
                    end
                    default: data_out_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        // Edge history tracks the inputs even in reset so held levels are not re-captured.
        req_rd_q <= req_rd;
        req_wr_q <= req_wr;
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_ch_q  <= '0;
            rr_ptr_q    <= IDX_W'(NUM_CH - 1);
            pend_q      <= '0;
            dir_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sec_q[i] <= '0;
            end
            irq_q       <= 1'b0;
            ch_done_q   <= '0;
            ch_err_q    <= '0;
            data_out_q  <= '0;
            command_q   <= '0;
            byte_cnt_q  <= 4'd15;
            tsec_q      <= '0;
            be_sector_q <= '0;
            be_rstart_q <= 1'b0;
            be_wstart_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_ch_q  <= grant_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            pend_q      <= pend_d;
            dir_q       <= dir_d;
            sec_q       <= sec_d;
            irq_q       <= irq_d;
            ch_done_q   <= ch_done_d;
            ch_err_q    <= ch_err_d;
            data_out_q  <= data_out_d;
            command_q   <= command_d;
            byte_cnt_q  <= byte_cnt_d;
            tsec_q      <= tsec_d;
            be_sector_q <= be_sector_d;
            be_rstart_q <= be_rstart_d;
            be_wstart_q <= be_wstart_d;
        end
    end

    assign ch_done   = ch_done_q;
    assign ch_err    = ch_err_q;
    assign data_out  = data_out_q;
    assign irq       = irq_q;
    assign be_rstart = be_rstart_q;
    assign be_wstart = be_wstart_q;
    assign be_sector = be_sector_q;

endmodule
